gpio_ctrl: RTL and testbench

// - Bus-mapped controller for the SoC GPIO block: a CPU-side register port drives the LEDs and reads the switches.
// - Synchronises and debounces the switch inputs, then raises a maskable level interrupt when a debounced switch changes.
// - Generates a free-running blink clock (xclk) that can gate the LED outputs.
// - Sits between the SoC peripheral bus and the board pins.

---
 rtl/gpio_pkg.sv | 13 +
 rtl/gpio_debounce.sv | 31 +++
 rtl/gpio_ctrl.sv | 85 ++++++++
 tb/tb_gpio_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register map, CTRL field position and bus FSM encoding shared by the GPIO controller
package gpio_pkg;
  localparam logic [1:0] ADDR_LED_OUT = 2'd0;
  localparam logic [1:0] ADDR_SW_IN = 2'd1;
  localparam logic [1:0] ADDR_IRQ_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;
  localparam int CTRL_BLINK_BIT = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: 2-FF synchroniser plus stability counter for one switch bit
// Ports: clk, rst (async, active-high); din raw pin; stable debounced level;
// chg one-cycle strobe on the edge where stable takes a new value.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic chg
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  // Fires on the last cycle of a full disagreement run, so stable updates and chg coincide.
  assign chg = (sync[1] != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == stable) cnt <= '0;
      else if (chg) begin
        stable <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: bus-mapped LED/switch controller with debounced switch-change interrupts and blink clock
// Ports: clk, rst (async, active-high); bus_sel/bus_we/bus_addr/bus_wdata request side;
// bus_rdata/bus_ack one-cycle response; bus_sw raw switches; bus_leds LED pins;
// xclk blink clock; irq level interrupt.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int N_GPIO = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PRESC_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_sel,
  input  logic              bus_we,
  input  logic [1:0]        bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ack,
  input  logic [N_GPIO-1:0] bus_sw,
  output logic [N_GPIO-1:0] bus_leds,
  output logic              xclk,
  output logic              irq
);
  state_t state;
  logic [N_GPIO-1:0] led_out, irq_en, irq_status, sw_stable, chg, clr;
  logic blink_en;
  logic [PRESC_W-1:0] presc;
  logic [31:0] rd_word, ctrl_word;
  logic wr_stb;
  for (genvar i = 0; i < N_GPIO; i++) begin : g_deb
    gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk),
      .rst(rst),
      .din(bus_sw[i]),
      .stable(sw_stable[i]),
      .chg(chg[i])
    );
  end
  assign wr_stb = (state == IDLE) && bus_sel && bus_we;
  assign clr = (wr_stb && bus_addr == ADDR_IRQ_STATUS) ? bus_wdata[N_GPIO-1:0] : '0;
  assign ctrl_word = 32'(irq_en) | (32'(blink_en) << CTRL_BLINK_BIT);
  always_comb
    rd_word = bus_addr == ADDR_LED_OUT ? 32'(led_out) :
              bus_addr == ADDR_SW_IN ? 32'(sw_stable) :
              bus_addr == ADDR_IRQ_STATUS ? 32'(irq_status) : ctrl_word;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus_ack <= 1'b0;
      bus_rdata <= '0;
      led_out <= '0;
      irq_en <= '0;
      blink_en <= 1'b0;
    end else begin
      bus_ack <= 1'b0;
      bus_rdata <= '0;
      case (state)
        IDLE:
          if (bus_sel) begin
            state <= ACK;
            bus_ack <= 1'b1;
            bus_rdata <= bus_we ? '0 : rd_word;
            if (bus_we && bus_addr == ADDR_LED_OUT) led_out <= bus_wdata[N_GPIO-1:0];
            if (bus_we && bus_addr == ADDR_CTRL) begin
              irq_en <= bus_wdata[N_GPIO-1:0];
              blink_en <= bus_wdata[CTRL_BLINK_BIT];
            end
          end
        ACK: state <= HOLD;
        HOLD: if (!bus_sel) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  // OR-ing the set after the clear makes a coincident edge win over W1C.
  always_ff @(posedge clk or posedge rst)
    if (rst) irq_status <= '0;
    else irq_status <= (irq_status & ~clr) | (chg & irq_en);
  always_ff @(posedge clk or posedge rst)
    if (rst) presc <= '0;
    else presc <= presc + 1'b1;
  assign xclk = presc[PRESC_W-1];
  assign irq = |irq_status;
  assign bus_leds = blink_en ? (led_out & {N_GPIO{xclk}}) : led_out;
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed scoreboard bench for gpio_ctrl with short debounce and prescaler
module tb_gpio_ctrl;
  logic clk, rst, bus_sel, bus_we, bus_ack, xclk, irq;
  logic [1:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic [3:0] bus_sw, bus_leds;
  int checks = 0, errors = 0, ack_count = 0, deb_n = 0;
  logic [32:0] exp_q[$];
  string tag_q[$];
  logic [32:0] sb_e;
  string sb_t;
  gpio_ctrl #(.N_GPIO(4), .DEBOUNCE_CYCLES(4), .PRESC_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus_sel(bus_sel),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack(bus_ack),
    .bus_sw(bus_sw),
    .bus_leds(bus_leds),
    .xclk(xclk),
    .irq(irq)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (bus_ack === 1'b1) begin
      ack_count++;
      chk("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        sb_e = exp_q.pop_front();
        sb_t = tag_q.pop_front();
        if (sb_e[32]) chk(sb_t, bus_rdata, sb_e[31:0]);
      end
    end
  task automatic access(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, input int hold, input string tag);
    int a0, n;
    a0 = ack_count;
    exp_q.push_back({~we, exp});
    tag_q.push_back(tag);
    bus_sel = 1'b1;
    bus_we = we;
    bus_addr = addr;
    bus_wdata = wd;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (ack_count == a0 && n < 10);
    chk({tag, "_lat"}, 32'(n), 32'd2);
    repeat (hold) @(negedge clk);
    chk({tag, "_acks"}, 32'(ack_count - a0), 32'd1);
    @(negedge clk);
    bus_sel = 1'b0;
    bus_we = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int n, a0;
    logic px;
    rst = 1'b1;
    bus_sel = 1'b0;
    bus_we = 1'b0;
    bus_addr = '0;
    bus_wdata = '0;
    bus_sw = '0;
    #2;
    chk("rst_ack", 32'(bus_ack), 0);
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_leds", 32'(bus_leds), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_xclk", 32'(xclk), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access(1, 2'd0, 32'hA, 0, 0, "wr_led_a");
    chk("leds_a", 32'(bus_leds), 32'hA);
    access(0, 2'd0, 0, 32'h0000_000A, 0, "rd_led_a");
    access(1, 2'd0, 32'h5, 0, 10, "wr_led_hold");
    access(0, 2'd0, 0, 32'h5, 0, "rd_led_5");
    access(1, 2'd1, 32'hF, 0, 0, "wr_sw_ignored");
    access(0, 2'd1, 0, 32'h0, 0, "rd_sw_0");
    access(0, 2'd3, 0, 32'h0, 0, "rd_ctrl_0");
    bus_sw[0] = 1'b1;
    repeat (2) @(negedge clk);
    bus_sw[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_irq", 32'(irq), 0);
    access(0, 2'd1, 0, 32'h0, 0, "rd_sw_glitch");
    access(1, 2'd3, 32'h1, 0, 0, "wr_ctrl_1");
    access(0, 2'd3, 0, 32'h1, 0, "rd_ctrl_1");
    bus_sw[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (irq !== 1'b1 && n < 20);
    deb_n = n;
    chk("deb_lat_in_range", 32'(n >= 5 && n <= 7), 1);
    access(0, 2'd1, 0, 32'h1, 0, "rd_sw_1");
    chk("irq_set", 32'(irq), 1);
    access(0, 2'd2, 0, 32'h1, 0, "rd_status_1");
    access(1, 2'd2, 32'h1, 0, 0, "w1c_0");
    chk("irq_cleared", 32'(irq), 0);
    access(0, 2'd2, 0, 32'h0, 0, "rd_status_0");
    bus_sw[1] = 1'b1;
    repeat (10) @(negedge clk);
    chk("masked_irq", 32'(irq), 0);
    access(0, 2'd1, 0, 32'h3, 0, "rd_sw_3");
    access(0, 2'd2, 0, 32'h0, 0, "rd_status_masked");
    bus_sw[0] = 1'b0;
    repeat (deb_n - 1) @(negedge clk);
    access(1, 2'd2, 32'h1, 0, 0, "w1c_coincide");
    chk("set_wins_irq", 32'(irq), 1);
    access(0, 2'd2, 0, 32'h1, 0, "rd_status_set_wins");
    access(0, 2'd1, 0, 32'h2, 0, "rd_sw_2");
    access(1, 2'd2, 32'hF, 0, 0, "w1c_all");
    chk("irq_clear_all", 32'(irq), 0);
    access(1, 2'd0, 32'hF, 0, 0, "wr_led_f");
    access(1, 2'd3, 32'h100, 0, 0, "wr_ctrl_blink");
    access(0, 2'd3, 0, 32'h100, 0, "rd_ctrl_blink");
    px = xclk;
    n = 0;
    while (xclk === px && n < 20) begin
      @(negedge clk);
      n++;
    end
    px = xclk;
    n = 0;
    do begin
      chk("blink_leds", 32'(bus_leds), {28'd0, {4{xclk}}});
      @(negedge clk);
      n++;
    end while (xclk === px && n < 20);
    chk("xclk_half_period", 32'(n), 8);
    chk("blink_leds_flip", 32'(bus_leds), {28'd0, {4{xclk}}});
    access(1, 2'd3, 32'h0, 0, 0, "wr_ctrl_off");
    chk("leds_steady_f", 32'(bus_leds), 32'hF);
    a0 = ack_count;
    bus_sel = 1'b1;
    bus_we = 1'b0;
    bus_addr = 2'd0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_ack", 32'(bus_ack), 0);
    chk("midrst_rdata", bus_rdata, 0);
    chk("midrst_leds", 32'(bus_leds), 0);
    chk("midrst_irq", 32'(irq), 0);
    chk("midrst_xclk", 32'(xclk), 0);
    bus_sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_ack", 32'(ack_count - a0), 0);
    access(0, 2'd0, 0, 32'h0, 0, "rd_led_after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
